// File: rtl/tick_run_ctrl.sv
// -----------------------------------------------------------------------------
// tick_run_ctrl
//
// Run-control and tick generator for a 4-bit synchronous down-counter.
// Start/stop button levels are edge-detected and drive an IDLE/RUN/PAUSE/DONE
// state machine. While running, a prescaler produces a single-cycle enable
// pulse every DIV clocks. In one-shot mode the run ends once the counter,
// fed back on count_in, returns to 0 after a tick. That gives one full
// 16-tick countdown from 0.
//
// Parameters
//   DIV        clk cycles per tick (2..65535)
//   PW         prescaler width, 2**PW >= DIV
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   button level; rising edge starts or resumes a run
//   stop       in   button level; rising edge pauses, or aborts when paused
//   mode       in   0 = free-run, 1 = one-shot (latched on IDLE->RUN)
//   count_in   in   [3:0] down-counter value fed back (bit 3 = MSB)
//   en         out  single-cycle tick to the down-counter enable
//   running    out  high while in RUN
//   paused     out  high while in PAUSE
//   done       out  one-cycle pulse at the end of a one-shot run
//   dbg_state  out  [1:0] current state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE)
// -----------------------------------------------------------------------------
module tick_run_ctrl #(
    parameter int DIV = 4,
    parameter int PW  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic [3:0] count_in,
    output logic       en,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic          r_pend;
    logic          r_mode;
    logic          r_start_q;
    logic          r_stop_q;
    logic          r_en;
    logic          r_running;
    logic          r_paused;
    logic          r_done;

    logic          w_rise_start;
    logic          w_rise_stop;
    logic [PW-1:0] w_pre_inc;
    logic          w_oneshot_end;
    state_t        w_state_nx;
    logic [PW-1:0] w_pre_nx;
    logic          w_mode_nx;

    // Next-state and prescaler logic. Stop outranks start on a shared edge.
    // The one-shot termination outranks everything in the cycle after a tick.
    always_comb begin
        w_rise_start  = start & ~r_start_q;
        w_rise_stop   = stop & ~r_stop_q;
        w_pre_inc     = (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
        w_oneshot_end = r_pend && r_mode && (count_in == 4'd0);
        w_state_nx    = r_state;
        w_pre_nx      = r_pre;
        w_mode_nx     = r_mode;

        case (r_state)
            ST_IDLE: begin
                if (w_rise_start && !w_rise_stop) begin
                    w_state_nx = ST_RUN;
                    w_pre_nx   = '0;
                    w_mode_nx  = mode;
                end
            end
            ST_RUN: begin
                if (w_oneshot_end) begin
                    w_state_nx = ST_DONE;
                    w_pre_nx   = '0;
                end else if (w_rise_stop) begin
                    // Prescaler holds so that a resume keeps the tick phase.
                    w_state_nx = ST_PAUSE;
                end else begin
                    w_pre_nx = w_pre_inc;
                end
            end
            ST_PAUSE: begin
                if (w_rise_stop) begin
                    w_state_nx = ST_IDLE;
                    w_pre_nx   = '0;
                end else if (w_rise_start) begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
                w_pre_nx   = '0;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_pre_nx   = '0;
            end
        endcase
    end

    // State, prescaler and registered outputs. Each output is registered from
    // the next-state values. For example, r_en always equals
    // (state == RUN && pre == DIV-1), so it has no combinational input path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pre     <= '0;
            r_pend    <= 1'b0;
            r_mode    <= 1'b0;
            // Loaded high so that a button held through reset does not fire.
            r_start_q <= 1'b1;
            r_stop_q  <= 1'b1;
            r_en      <= 1'b0;
            r_running <= 1'b0;
            r_paused  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_start_q <= start;
            r_stop_q  <= stop;
            r_state   <= w_state_nx;
            r_pre     <= w_pre_nx;
            r_mode    <= w_mode_nx;
            // pend marks the cycle where the counter shows its post-tick value.
            r_pend    <= r_en;
            r_en      <= (w_state_nx == ST_RUN) && (w_pre_nx == PRE_LAST);
            r_running <= (w_state_nx == ST_RUN);
            r_paused  <= (w_state_nx == ST_PAUSE);
            r_done    <= (w_state_nx == ST_DONE);
        end
    end

    assign en        = r_en;
    assign running   = r_running;
    assign paused    = r_paused;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_tick_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tick_run_ctrl
//
// Directed bench for tick_run_ctrl with DIV = 4. A behavioural 4-bit
// down-counter closes the loop from en back to count_in. Expected values are
// hand-derived from the run-control timing. E0 is the edge that samples the
// start rise, and step i is the cycle just after edge E0+i.
// -----------------------------------------------------------------------------
module tb_tick_run_ctrl;

    localparam int DIV = 4;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       mode;
    logic [3:0] cnt;
    logic       en;
    logic       running;
    logic       paused;
    logic       done;
    logic [1:0] dbg_state;

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_en;
    logic [3:0] exp_q[$];

    tick_run_ctrl #(.DIV(DIV), .PW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .count_in  (cnt),
        .en        (en),
        .running   (running),
        .paused    (paused),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Down-counter driven by en and cleared by the shared reset.
    always @(posedge clk) begin
        if (reset)   cnt <= 4'd0;
        else if (en) cnt <= cnt - 4'd1;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        stop  = 1'b0;
        mode  = 1'b0;
        repeat (3) tick();

        // Reset state
        chk1("rst_en", en, 1'b0);
        chk1("rst_running", running, 1'b0);
        chk1("rst_paused", paused, 1'b0);
        chk1("rst_done", done, 1'b0);
        chkn("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // Start held through reset never fires
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("held_en", en, 1'b0);
            chk1("held_running", running, 1'b0);
        end
        start = 1'b0;
        tick();

        // One-shot from count 0: 16 ticks, done at E0+65
        for (int k = 15; k >= 0; k--) exp_q.push_back(4'(k));
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_en  = 0;
        for (int i = 0; i <= 66; i++) begin
            if (i > 0) tick();
            chk1("os_en", en, (i % 4 == 3) && (i <= 63));
            chk1("os_running", running, i <= 64);
            chk1("os_done", done, i == 65);
            if (en) n_en++;
            if ((i % 4 == 0) && (i >= 4) && (i <= 64))
                chkn("os_count", 32'(cnt), 32'(exp_q.pop_front()));
        end
        chkn("os_en_total", n_en, 16);
        chkn("os_final_state", 32'(dbg_state), 32'(S_IDLE));

        // Free-run for 100 cycles, mode toggled mid-run
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_en  = 0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) tick();
            if (i == 50) mode = 1'b1;
            chk1("fr_en", en, i % 4 == 3);
            chk1("fr_done", done, 1'b0);
            chk1("fr_running", running, 1'b1);
            if (en) n_en++;
            if (i == 4) chkn("fr_wrap", 32'(cnt), 32'd15);
        end
        chkn("fr_en_total", n_en, 25);
        chkn("fr_count", 32'(cnt), 32'd8);
        stop = 1'b1;
        tick();
        chk1("fr_pause", paused, 1'b1);
        stop = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        chkn("fr_abort_state", 32'(dbg_state), 32'(S_IDLE));
        stop = 1'b0;
        tick();

        // Pause at pre = 2, hold, resume keeps phase
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk1("pz_paused", paused, 1'b1);
        chk1("pz_running", running, 1'b0);
        chk1("pz_en_suppressed", en, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("pz_hold_en", en, 1'b0);
            chk1("pz_hold_paused", paused, 1'b1);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("rs_running", running, 1'b1);
        chk1("rs_en0", en, 1'b0);
        tick();
        chk1("rs_en1", en, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk1("rs_en_next", en, k == 5);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chkn("ab_pause_state", 32'(dbg_state), 32'(S_PAUSE));
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chkn("ab_idle_state", 32'(dbg_state), 32'(S_IDLE));
        chk1("ab_paused", paused, 1'b0);
        tick();

        // Fresh start after abort: prescaler restarted from 0
        start = 1'b1;
        tick();
        start = 1'b0;
        chkn("ab_restart_state", 32'(dbg_state), 32'(S_RUN));
        tick();
        tick();
        chk1("ab_restart_en2", en, 1'b0);
        tick();
        chk1("ab_restart_en3", en, 1'b1);

        // Simultaneous start/stop edges: RUN->PAUSE, PAUSE->IDLE, IDLE stays
        start = 1'b1;
        stop  = 1'b1;
        tick();
        chkn("sim_run_state", 32'(dbg_state), 32'(S_PAUSE));
        start = 1'b0;
        stop  = 1'b0;
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        chkn("sim_pause_state", 32'(dbg_state), 32'(S_IDLE));
        start = 1'b0;
        stop  = 1'b0;
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        chkn("sim_idle_state", 32'(dbg_state), 32'(S_IDLE));
        chk1("sim_idle_running", running, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        tick();
        chkn("sim_idle_after", 32'(dbg_state), 32'(S_IDLE));

        // Stop rise in the pend cycle of the final one-shot tick: DONE wins
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (64) tick();
        chkn("pend_count", 32'(cnt), 32'd0);
        chk1("pend_running", running, 1'b1);
        stop = 1'b1;
        tick();
        chk1("pend_done", done, 1'b1);
        chkn("pend_state", 32'(dbg_state), 32'(S_DONE));
        chk1("pend_paused", paused, 1'b0);
        stop = 1'b0;
        tick();
        chk1("pend_done_gone", done, 1'b0);
        chkn("pend_idle", 32'(dbg_state), 32'(S_IDLE));

        // Reset mid-run at count 7, then a clean run
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (36) tick();
        chkn("mr_count7", 32'(cnt), 32'd7);
        chk1("mr_running", running, 1'b1);
        reset = 1'b1;
        tick();
        chkn("mr_state", 32'(dbg_state), 32'(S_IDLE));
        chk1("mr_en", en, 1'b0);
        chk1("mr_running_low", running, 1'b0);
        chkn("mr_count_clr", 32'(cnt), 32'd0);
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("cl_running", running, 1'b1);
        tick();
        tick();
        chk1("cl_en2", en, 1'b0);
        tick();
        chk1("cl_en3", en, 1'b1);
        tick();
        chkn("cl_count", 32'(cnt), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tick_run_ctrl.md
# tick_run_ctrl

Run-control and tick generator that sits directly upstream of the 4-bit synchronous down-counter. It turns start/stop button levels into a RUN/PAUSE state machine and drives the counter's enable input with single-cycle pulses from a programmable prescaler. It also watches the counter's output. In one-shot mode it ends the run once the count returns to 0, giving one full 16-tick countdown.

## Interface
- DIV, default 4: clk cycles per tick; legal range 2..65535.
- PW, default 16: prescaler register width; must satisfy 2^PW >= DIV.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  button level; its rising edge starts or resumes a run.
- stop  in  1  button level; its rising edge pauses a run, or aborts it if already paused.
- mode  in  1  0 = free-run, 1 = one-shot. Sampled only on the IDLE->RUN transition.
- count_in  in  4  counter value (q4..q1, q4 = MSB) fed back from the down-counter.
- en  out  1  single-cycle tick to the down-counter enable.
- running  out  1  high while state is RUN.
- paused  out  1  high while state is PAUSE.
- done  out  1  one-cycle pulse at the end of a one-shot run.

## Operation
- Edge detect:
  - start_q and stop_q are registered copies of the inputs.
  - rise_start = start & ~start_q; rise_stop = stop & ~stop_q.
  - Reset loads start_q = stop_q = 1, so a button held through reset does not fire.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - rise_start -> RUN; pre cleared to 0; mode latched into mode_r; pend cleared.
  - rise_stop is ignored.
- RUN:
  - pre increments each cycle and wraps from DIV-1 to 0.
  - en = (state==RUN) && (pre==DIV-1). en is a decode of registered state only, with no input paths.
  - Each en cycle sets pend for the following cycle.
  - pend && mode_r && count_in==0 -> DONE.
  - Otherwise rise_stop -> PAUSE; pre holds its value.
- PAUSE:
  - pre holds; en = 0.
  - rise_start -> RUN and resumes from the held pre.
  - rise_stop -> IDLE; pre cleared.
- DONE: done = 1 for exactly one cycle, then -> IDLE unconditionally. Start/stop edges in this cycle are ignored.
- Simultaneous events:
  - rise_start and rise_stop in the same cycle: stop wins (RUN -> PAUSE, PAUSE -> IDLE, IDLE stays).
  - In the pend cycle, the one-shot termination check outranks rise_stop.
- Free-run (mode_r = 0): never enters DONE. Ticks continue indefinitely and the counter wraps 0 -> 15 on its own.
- Changing mode while not in IDLE has no effect.
- Reset mid-run: next state is IDLE, pre = 0, pend = 0, en = 0. The down-counter is reset by the same reset line.

## Timing
- Reset values: en = 0, running = 0, paused = 0, done = 0; state IDLE; pre = 0; pend = 0; mode_r = 0.
- Let E0 be the clock edge at which rise_start is sampled in IDLE.
  - First en is high between edge E0+DIV-1 and E0+DIV; the counter samples it at E0+DIV.
  - Later ticks repeat every DIV cycles.
- The counter's new value is visible one cycle after the en cycle, which is exactly the pend cycle.
- One-shot run starting from count 0:
  - The 16th tick is sampled at E0+16·DIV and count_in reads 0 after it.
  - DONE is entered at E0+16·DIV+1; done is high for that cycle; IDLE at E0+16·DIV+2.
- Pause latency: rise_stop sampled at edge E -> running low and paused high after E. Any en that would have been asserted after E is suppressed.
- Resume keeps phase: the remaining cycles to the next tick equal those left at the pause.
- DIV >= 2 guarantees the pend cycle never coincides with an en cycle.

## Test plan
- Reset with start held high, then hold start -> no run; en = 0, running = 0 indefinitely.
- DIV = 4, mode = 1, counter at 0, pulse start:
  - en high in cycles E0+3, +7, … +63 (16 pulses); count steps 15..0.
  - done pulse at E0+65; then IDLE, running = 0.
- DIV = 4, mode = 0, run 100 cycles:
  - 25 en pulses, counter wraps 0 -> 15 with no done.
  - Changing mode mid-run has no effect.
- Pause/resume, DIV = 4:
  - stop rise when pre = 2 -> paused = 1, en held low over 10 cycles.
  - start rise -> next en exactly 2 cycles later.
  - Second stop while paused -> IDLE, pre = 0.
- Simultaneous start and stop rising edges:
  - in RUN -> PAUSE; in IDLE -> stays IDLE.
  - stop rise in the pend cycle with count_in = 0, one-shot -> DONE wins, done = 1.
- Reset asserted mid-run at count 7 -> IDLE after the edge, en = 0, running = 0; a fresh start behaves as a clean run.
